// File: rtl/commit_trace_fifo.sv
// Commit-trace recorder: one retired instruction per cycle into a FIFO,
// drained over a valid/ready port with first-word fall-through.
module commit_trace_fifo #(
  parameter int DEPTH    = 16,
  parameter int PC_W     = 16,
  parameter int REG_W    = 3,
  parameter int CNT_W    = 32,
  parameter int LOG_NOPS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cm_valid,
  input  logic [PC_W-1:0]          cm_pc,
  input  logic                     cm_regwrite,
  input  logic [REG_W-1:0]         cm_wreg,
  input  logic [PC_W-1:0]          cm_wdata,
  input  logic                     cm_memread,
  input  logic                     cm_memwrite,
  input  logic [PC_W-1:0]          cm_maddr,
  input  logic [PC_W-1:0]          cm_mdata,
  input  logic                     cm_halt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_inum,
  output logic [CNT_W-1:0]         out_cycle,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               out_flags,
  output logic [REG_W-1:0]         out_wreg,
  output logic [PC_W-1:0]          out_wdata,
  output logic [PC_W-1:0]          out_maddr,
  output logic [PC_W-1:0]          out_mdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         inst_count,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow,
  output logic                     halted,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [CNT_W-1:0] r_inum  [DEPTH];
  logic [CNT_W-1:0] r_cyst  [DEPTH];
  logic [PC_W-1:0]  r_pc    [DEPTH];
  logic [3:0]       r_flg   [DEPTH];
  logic [REG_W-1:0] r_wreg  [DEPTH];
  logic [PC_W-1:0]  r_wdata [DEPTH];
  logic [PC_W-1:0]  r_maddr [DEPTH];
  logic [PC_W-1:0]  r_mdata [DEPTH];

  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_inst;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_drop;
  logic             r_ovf;
  logic             r_halt;

  logic w_accept;
  logic w_log;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_accept = cm_valid & ~r_halt;
  assign w_log    = w_accept & ((LOG_NOPS != 0) | cm_regwrite
                  | cm_memwrite | cm_halt);
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_pop    = out_valid & out_ready;
  assign w_push   = w_log & (~w_full | w_pop);
  assign w_drop   = w_log & w_full & ~w_pop;

  // Entry storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inum[r_wr]  <= r_inst;
      r_cyst[r_wr]  <= r_cyc;
      r_pc[r_wr]    <= cm_pc;
      r_flg[r_wr]   <= {cm_halt, cm_memwrite, cm_memread, cm_regwrite};
      r_wreg[r_wr]  <= cm_wreg;
      r_wdata[r_wr] <= cm_wdata;
      r_maddr[r_wr] <= cm_maddr;
      r_mdata[r_wr] <= cm_mdata;
    end
  end

  // Pointers, occupancy, counters and halt/overflow status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_inst  <= '0;
      r_cyc   <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (!r_halt) r_cyc <= r_cyc + CNT_W'(1);
      if (w_accept) r_inst <= r_inst + CNT_W'(1);
      if (w_accept && cm_halt) r_halt <= 1'b1;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + CNT_W'(1);
      end
    end
  end

  assign out_valid   = (r_level != '0);
  assign out_inum    = r_inum[r_rd];
  assign out_cycle   = r_cyst[r_rd];
  assign out_pc      = r_pc[r_rd];
  assign out_flags   = {r_flg[r_rd], 1'b1};
  assign out_wreg    = r_wreg[r_rd];
  assign out_wdata   = r_wdata[r_rd];
  assign out_maddr   = r_maddr[r_rd];
  assign out_mdata   = r_mdata[r_rd];
  assign level       = r_level;
  assign inst_count  = r_inst;
  assign cycle_count = r_cyc;
  assign drop_count  = r_drop;
  assign overflow    = r_ovf;
  assign halted      = r_halt;
  assign done        = r_halt & (r_level == '0);

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: two configurations on shared stimulus,
// checked against a queue-based reference model.
module tb_commit_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        cm_valid, cm_regwrite, cm_memread, cm_memwrite, cm_halt;
  logic [15:0] cm_pc, cm_wdata, cm_maddr, cm_mdata;
  logic [2:0]  cm_wreg;
  logic        out_ready;

  always #5 clk = ~clk;

  logic        o0_valid, o0_ovf, o0_halt, o0_done;
  logic [31:0] o0_inum, o0_cyc, o0_inst, o0_ccnt, o0_drop;
  logic [15:0] o0_pc, o0_wdata, o0_maddr, o0_mdata;
  logic [4:0]  o0_flags;
  logic [2:0]  o0_wreg;
  logic [2:0]  o0_level;

  logic        o1_valid, o1_ovf, o1_halt, o1_done;
  logic [7:0]  o1_inum, o1_cyc, o1_inst, o1_ccnt, o1_drop;
  logic [15:0] o1_pc, o1_wdata, o1_maddr, o1_mdata;
  logic [4:0]  o1_flags;
  logic [2:0]  o1_wreg;
  logic [3:0]  o1_level;

  commit_trace_fifo #(
    .DEPTH(4), .PC_W(16), .REG_W(3), .CNT_W(32), .LOG_NOPS(0)
  ) u0 (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc),
    .cm_regwrite(cm_regwrite), .cm_wreg(cm_wreg), .cm_wdata(cm_wdata),
    .cm_memread(cm_memread), .cm_memwrite(cm_memwrite),
    .cm_maddr(cm_maddr), .cm_mdata(cm_mdata), .cm_halt(cm_halt),
    .out_valid(o0_valid), .out_ready(out_ready), .out_inum(o0_inum),
    .out_cycle(o0_cyc), .out_pc(o0_pc), .out_flags(o0_flags),
    .out_wreg(o0_wreg), .out_wdata(o0_wdata), .out_maddr(o0_maddr),
    .out_mdata(o0_mdata), .level(o0_level), .inst_count(o0_inst),
    .cycle_count(o0_ccnt), .drop_count(o0_drop), .overflow(o0_ovf),
    .halted(o0_halt), .done(o0_done)
  );

  commit_trace_fifo #(
    .DEPTH(8), .PC_W(16), .REG_W(3), .CNT_W(8), .LOG_NOPS(1)
  ) u1 (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc),
    .cm_regwrite(cm_regwrite), .cm_wreg(cm_wreg), .cm_wdata(cm_wdata),
    .cm_memread(cm_memread), .cm_memwrite(cm_memwrite),
    .cm_maddr(cm_maddr), .cm_mdata(cm_mdata), .cm_halt(cm_halt),
    .out_valid(o1_valid), .out_ready(out_ready), .out_inum(o1_inum),
    .out_cycle(o1_cyc), .out_pc(o1_pc), .out_flags(o1_flags),
    .out_wreg(o1_wreg), .out_wdata(o1_wdata), .out_maddr(o1_maddr),
    .out_mdata(o1_mdata), .level(o1_level), .inst_count(o1_inst),
    .cycle_count(o1_ccnt), .drop_count(o1_drop), .overflow(o1_ovf),
    .halted(o1_halt), .done(o1_done)
  );

  typedef struct {
    int unsigned inum, cyc, pc, flags, wreg, wdata, maddr, mdata;
  } ent_t;

  ent_t        q0[$];
  ent_t        q1[$];
  int unsigned m_inst[2], m_cyc[2], m_drop[2];
  bit          m_ovf[2], m_halt[2];
  int unsigned mask[2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  int          dep[2]  = '{4, 8};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: one clock of the recorder, from pre-edge inputs.
  task automatic model();
    ent_t e;
    bit   acc, lg, pop, full;
    int   sz;
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        m_inst[k] = 0; m_cyc[k] = 0; m_drop[k] = 0;
        m_ovf[k] = 0;  m_halt[k] = 0;
      end
      return;
    end
    for (int k = 0; k < 2; k++) begin
      acc  = cm_valid && !m_halt[k];
      lg   = acc && (k == 1 || cm_regwrite || cm_memwrite || cm_halt);
      sz   = (k == 0) ? q0.size() : q1.size();
      pop  = (sz > 0) && out_ready;
      full = (sz == dep[k]);
      e.inum  = m_inst[k];
      e.cyc   = m_cyc[k];
      e.pc    = cm_pc;
      e.flags = {cm_halt, cm_memwrite, cm_memread, cm_regwrite, 1'b1};
      e.wreg  = cm_wreg;
      e.wdata = cm_wdata;
      e.maddr = cm_maddr;
      e.mdata = cm_mdata;
      if (pop) begin
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
      if (lg) begin
        if (!full || pop) begin
          if (k == 0) q0.push_back(e);
          else        q1.push_back(e);
        end else begin
          if (m_drop[k] != mask[k]) m_drop[k]++;
          m_ovf[k] = 1;
        end
      end
      if (!m_halt[k]) m_cyc[k] = (m_cyc[k] + 1) & mask[k];
      if (acc) m_inst[k] = (m_inst[k] + 1) & mask[k];
      if (acc && cm_halt) m_halt[k] = 1;
    end
  endtask

  task automatic compare_all();
    ent_t h;
    check("u0.valid", o0_valid, q0.size() != 0);
    check("u0.level", o0_level, q0.size());
    check("u0.inst",  o0_inst,  m_inst[0]);
    check("u0.cycle", o0_ccnt,  m_cyc[0]);
    check("u0.drop",  o0_drop,  m_drop[0]);
    check("u0.ovf",   o0_ovf,   m_ovf[0]);
    check("u0.halt",  o0_halt,  m_halt[0]);
    check("u0.done",  o0_done,  m_halt[0] && q0.size() == 0);
    if (q0.size() != 0) begin
      h = q0[0];
      check("u0.h_inum",  o0_inum,  h.inum);
      check("u0.h_cyc",   o0_cyc,   h.cyc);
      check("u0.h_pc",    o0_pc,    h.pc);
      check("u0.h_flags", o0_flags, h.flags);
      check("u0.h_wreg",  o0_wreg,  h.wreg);
      check("u0.h_wdata", o0_wdata, h.wdata);
      check("u0.h_maddr", o0_maddr, h.maddr);
      check("u0.h_mdata", o0_mdata, h.mdata);
    end
    check("u1.valid", o1_valid, q1.size() != 0);
    check("u1.level", o1_level, q1.size());
    check("u1.inst",  o1_inst,  m_inst[1]);
    check("u1.cycle", o1_ccnt,  m_cyc[1]);
    check("u1.drop",  o1_drop,  m_drop[1]);
    check("u1.ovf",   o1_ovf,   m_ovf[1]);
    check("u1.halt",  o1_halt,  m_halt[1]);
    check("u1.done",  o1_done,  m_halt[1] && q1.size() == 0);
    if (q1.size() != 0) begin
      h = q1[0];
      check("u1.h_inum",  o1_inum,  h.inum);
      check("u1.h_cyc",   o1_cyc,   h.cyc);
      check("u1.h_pc",    o1_pc,    h.pc);
      check("u1.h_flags", o1_flags, h.flags);
      check("u1.h_wreg",  o1_wreg,  h.wreg);
      check("u1.h_wdata", o1_wdata, h.wdata);
      check("u1.h_maddr", o1_maddr, h.maddr);
      check("u1.h_mdata", o1_mdata, h.mdata);
    end
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic commit(input bit v, rw, mr, mw, hl,
                        input logic [2:0] wr,
                        input logic [15:0] wd, ma, md);
    cm_valid    = v;
    cm_regwrite = rw;
    cm_memread  = mr;
    cm_memwrite = mw;
    cm_halt     = hl;
    cm_wreg     = wr;
    cm_wdata    = wd;
    cm_maddr    = ma;
    cm_mdata    = md;
    cm_pc       = 16'($urandom);
    step();
  endtask

  task automatic idle();
    commit(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  logic [4:0]  fl[3] = '{5'h03, 5'h09, 5'h07};
  logic [31:0] last;

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    cm_valid = 0; cm_regwrite = 0; cm_memread = 0; cm_memwrite = 0;
    cm_halt = 0; cm_wreg = 0; cm_wdata = 0; cm_maddr = 0; cm_mdata = 0;
    cm_pc = 0;
    do_reset();
    check("rst.valid", o0_valid, 1'b0);
    check("rst.level", o0_level, 3'd0);

    // three commits, then drain and check flag encodings in order
    commit(1, 1, 0, 0, 0, 3'd2, 16'h0005, 16'h0, 16'h0);
    commit(1, 0, 0, 1, 0, 3'd0, 16'h0, 16'h0010, 16'hBEEF);
    commit(1, 1, 1, 0, 0, 3'd1, 16'h1234, 16'h0020, 16'h0);
    check("three.level", o0_level, 3'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("three.flags", o0_flags, fl[i]);
      check("three.inum", o0_inum, i);
      idle();
    end

    // nop not logged with LOG_NOPS=0, but counted
    do_reset();
    out_ready = 1'b0;
    commit(1, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0);
    commit(1, 1, 0, 0, 0, 3'd3, 16'h0001, 16'h0, 16'h0);
    check("nop.inst", o0_inst, 32'd2);
    check("nop.level", o0_level, 3'd1);
    check("nop.inum", o0_inum, 32'd1);

    // overflow on a full FIFO
    do_reset();
    for (int i = 0; i < 6; i++)
      commit(1, 1, 0, 0, 0, 3'(i), 16'(i), 16'h0, 16'h0);
    check("ovf.level", o0_level, 3'd4);
    check("ovf.drop", o0_drop, 32'd2);
    check("ovf.flag", o0_ovf, 1'b1);
    check("ovf.inum", o0_inum, 32'd0);

    // push and pop together on a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++)
      commit(1, 1, 0, 0, 0, 3'(i), 16'(i), 16'h0, 16'h0);
    out_ready = 1'b1;
    commit(1, 1, 0, 0, 0, 3'd7, 16'h00AA, 16'h0, 16'h0);
    check("pp.level", o0_level, 3'd4);
    check("pp.inum", o0_inum, 32'd1);
    last = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      last = o0_inum;
      idle();
    end
    check("pp.tail", last, 32'd4);

    // halt at cycle 7 with cm_valid held afterward
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++)
      commit(1, 1, 0, 0, 0, 3'd1, 16'(i), 16'h0, 16'h0);
    commit(1, 0, 0, 0, 1, 3'd0, 16'h0, 16'h0, 16'h0);
    check("halt.cyc", o0_cyc, 32'd7);
    check("halt.flags", o0_flags, 5'h11);
    for (int i = 0; i < 5; i++)
      commit(1, 1, 0, 0, 0, 3'd2, 16'h0, 16'h0, 16'h0);
    check("halt.halted", o0_halt, 1'b1);
    check("halt.ccnt", o0_ccnt, 32'd8);
    check("halt.inst", o0_inst, 32'd8);
    check("halt.done", o0_done, 1'b1);

    // reset mid-drain
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      commit(1, 1, 0, 1, 0, 3'd4, 16'(i), 16'(i), 16'(i));
    out_ready = 1'b1;
    rst = 1'b1;
    commit(1, 1, 0, 0, 0, 3'd5, 16'h0, 16'h0, 16'h0);
    rst = 1'b0;
    check("mid.valid", o0_valid, 1'b0);
    check("mid.level", o0_level, 3'd0);
    check("mid.inst", o0_inst, 32'd0);
    check("mid.ccnt", o0_ccnt, 32'd0);
    check("mid.ovf", o0_ovf, 1'b0);

    // drop counter saturation and counter wrap on the 8-bit config
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 300; i++)
      commit(1, 1, 0, 0, 0, 3'd6, 16'(i), 16'h0, 16'h0);
    check("sat.drop1", o1_drop, 8'hFF);
    check("sat.inst1", o1_inst, 8'd44);
    check("sat.drop0", o0_drop, 32'd296);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      commit(bit'($urandom_range(0, 9) < 7), bit'($urandom),
             bit'($urandom), bit'($urandom),
             bit'($urandom_range(0, 149) == 0),
             3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
